// File: rtl/anneal_phase_ctrl.sv
// anneal_phase_ctrl: sequences the 5-phase one-hot row enables, the bit_shift
// annealing code and the row reset for the sparse p-bit multiplier rows.
// Ports: clk, reset (sync, active-high), start, abort in;
//        phase_en[4:0], bit_shift[1:0], pbit_reset, busy, done,
//        sample_strobe, sweep_cnt[SWEEP_W-1:0] out.
module anneal_phase_ctrl #(
   parameter int N_PHASES        = 5,
   parameter int HOLD_CYCLES     = 1,
   parameter int SWEEPS_PER_STEP = 256,
   parameter int INIT_CYCLES     = 4,
   parameter int SWEEP_W         = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic [4:0]         phase_en,
   output logic [1:0]         bit_shift,
   output logic               pbit_reset,
   output logic               busy,
   output logic               done,
   output logic               sample_strobe,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN,
      DONE
   } state_t;

   state_t state, state_n;

   logic [15:0]        init_cnt;
   logic [15:0]        hold_cnt;
   logic [2:0]         phase;
   logic [1:0]         bs_q;
   logic [SWEEP_W-1:0] sc_q;

   logic init_last;
   logic hold_last;
   logic sweep_end;
   logic step_end;

   assign init_last = init_cnt == 16'(INIT_CYCLES - 1);
   assign hold_last = hold_cnt == 16'(HOLD_CYCLES - 1);
   assign sweep_end = (state == RUN) && hold_last &&
                      (phase == 3'(N_PHASES - 1));
   assign step_end  = sweep_end &&
                      (sc_q == SWEEP_W'(SWEEPS_PER_STEP - 1));

   assign bit_shift = bs_q;
   assign sweep_cnt = sc_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Leaving for IDLE (abort or DONE) clears everything, so INIT and
   // RUN always start from zeroed counters.
   always_ff @(posedge clk) begin
      if (reset || state_n == IDLE) begin
         init_cnt <= '0;
         hold_cnt <= '0;
         phase    <= '0;
         bs_q     <= '0;
         sc_q     <= '0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + 16'd1;
      end else if (state == RUN) begin
         if (hold_last) begin
            hold_cnt <= '0;
            if (phase == 3'(N_PHASES - 1)) phase <= '0;
            else                           phase <= phase + 3'd1;
         end else begin
            hold_cnt <= hold_cnt + 16'd1;
         end
         if (step_end) begin
            sc_q <= '0;
            // Final step exits to DONE; bit_shift holds 3 there.
            if (bs_q != 2'd3) bs_q <= bs_q + 2'd1;
         end else if (sweep_end) begin
            sc_q <= sc_q + SWEEP_W'(1);
         end
      end
   end

   always_comb begin
      state_n       = state;
      phase_en      = '0;
      pbit_reset    = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      sample_strobe = 1'b0;
      unique case (state)
         IDLE: begin
            pbit_reset = 1'b1;
            if (start && !abort) state_n = INIT;
         end
         INIT: begin
            pbit_reset = 1'b1;
            busy       = 1'b1;
            if (abort)          state_n = IDLE;
            else if (init_last) state_n = RUN;
         end
         RUN: begin
            busy          = 1'b1;
            phase_en      = 5'b00001 << phase;
            sample_strobe = sweep_end && (bs_q == 2'd3);
            if (abort)                           state_n = IDLE;
            else if (step_end && bs_q == 2'd3)   state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
